// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI4 types and constants for the memory responder.
//               Defines the burst and response encodings, the beat-size
//               constant, the responder state encoding and a helper that flags
//               address-phase errors.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Only full 32-bit beats are supported.
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_DATA  = 3'd1,
        W_RESP  = 3'd2,
        R_FETCH = 3'd3,
        R_BEAT  = 3'd4
    } slv_state_t;

    // Errors knowable from the address phase alone: narrow/wide beats and
    // WRAP or reserved burst types.
    function automatic logic addr_phase_err(input logic [2:0] size,
                                            input logic [1:0] burst);
        return (size != AXI_SIZE_4B) || (burst == WRAP) || (burst == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_bram.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_bram
// Description : Single-port word memory, DEPTH x 32, with per-byte write
//               enables and a registered (1-cycle) read. The read register
//               only updates while i_en is high, so its value is held between
//               accesses. Contents are not reset.
// Ports       : clk        - clock
//               i_en       - access enable (read and/or write)
//               i_we       - byte write enables, one per byte lane
//               i_addr     - word index
//               i_wdata    - write data
//               o_rdata    - registered read data (read-first)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_bram #(
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_slave
// Description : AXI4 memory responder serving single-beat and INCR/FIXED
//               bursts from on-chip word memory. One transaction at a time;
//               reads and writes alternate priority when both are requested.
//               Bad size/burst type, out-of-range beats and misplaced WLAST
//               are reported as SLVERR.
// Ports       : clk, rst_n (synchronous, active-low)
//               s_axi_aw* - write address channel (lock/cache/prot/qos ignored)
//               s_axi_w*  - write data channel
//               s_axi_b*  - write response channel
//               s_axi_ar* - read address channel (lock/cache/prot/qos ignored)
//               s_axi_r*  - read data channel
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // write address
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    // write response
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    // read address
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    // read data
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    slv_state_t              r_state;
    logic                    r_prio_rd;   // 1: read wins a simultaneous request
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [7:0]              r_cnt;
    logic [1:0]              r_burst;
    logic                    r_err;
    logic [ID_WIDTH-1:0]     r_bid;
    logic [1:0]              r_bresp;
    logic [ID_WIDTH-1:0]     r_rid;
    logic [1:0]              r_rresp;
    logic                    r_rlast;
    logic                    r_rbad;      // current R beat returns zero data

    logic                    w_aw_grant;
    logic                    w_ar_grant;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic [ADDR_WIDTH-1:0]   w_word;
    logic                    w_oor;
    logic                    w_last;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic                    w_wbeat;
    logic                    w_wbeat_err;
    logic                    w_mem_en;
    logic [3:0]              w_mem_we;
    logic [31:0]             w_mem_rdata;

    // Grants are combinational so ready can rise in the same cycle as valid.
    // Gating with rst_n keeps both readies low while reset is held.
    assign w_aw_grant = rst_n && (r_state == IDLE) && s_axi_awvalid &&
                        (!s_axi_arvalid || !r_prio_rd);
    assign w_ar_grant = rst_n && (r_state == IDLE) && s_axi_arvalid &&
                        (!s_axi_awvalid || r_prio_rd);

    // Word index of the current beat; the subtraction wraps for addresses
    // below the base, which the explicit compare catches.
    assign w_offset    = r_addr - BASE_ADDR;
    assign w_word      = w_offset >> 2;
    assign w_oor       = (r_addr < BASE_ADDR) || (w_word >= ADDR_WIDTH'(MEM_DEPTH));
    assign w_last      = (r_cnt == r_len);
    assign w_next_addr = (r_burst == FIXED) ? r_addr : r_addr + ADDR_WIDTH'(4);

    assign w_wbeat     = (r_state == W_DATA) && s_axi_wvalid;
    assign w_wbeat_err = r_err || w_oor || (s_axi_wlast != w_last);

    // A beat is only committed when no error has been seen before it.
    assign w_mem_we = (w_wbeat && !r_err && !w_oor) ? s_axi_wstrb : 4'b0000;
    assign w_mem_en = w_wbeat || (r_state == R_FETCH);

    axi_mem_bram #(
        .DEPTH   (MEM_DEPTH),
        .IDX_W   (c_IDX_W)
    ) u_bram (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (w_word[c_IDX_W-1:0]),
        .i_wdata (s_axi_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_prio_rd <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= '0;
            r_err     <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= '0;
            r_rid     <= '0;
            r_rresp   <= '0;
            r_rlast   <= 1'b0;
            r_rbad    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_aw_grant) begin
                        r_id      <= s_axi_awid;
                        r_addr    <= s_axi_awaddr;
                        r_len     <= s_axi_awlen;
                        r_burst   <= s_axi_awburst;
                        r_cnt     <= '0;
                        r_err     <= addr_phase_err(s_axi_awsize, s_axi_awburst);
                        r_prio_rd <= 1'b1;
                        r_state   <= W_DATA;
                    end else if (w_ar_grant) begin
                        r_id      <= s_axi_arid;
                        r_rid     <= s_axi_arid;
                        r_addr    <= s_axi_araddr;
                        r_len     <= s_axi_arlen;
                        r_burst   <= s_axi_arburst;
                        r_cnt     <= '0;
                        r_err     <= addr_phase_err(s_axi_arsize, s_axi_arburst);
                        r_prio_rd <= 1'b0;
                        r_state   <= R_FETCH;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        r_err <= w_wbeat_err;
                        if (w_last) begin
                            r_bid   <= r_id;
                            r_bresp <= w_wbeat_err ? SLVERR : OKAY;
                            r_state <= W_RESP;
                        end else begin
                            r_addr <= w_next_addr;
                            r_cnt  <= r_cnt + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_state <= IDLE;
                    end
                end
                R_FETCH: begin
                    // Beat status is captured here so it stays stable for the
                    // whole R_BEAT stall.
                    r_rbad  <= r_err || w_oor;
                    r_rresp <= (r_err || w_oor) ? SLVERR : OKAY;
                    r_rlast <= w_last;
                    r_err   <= r_err || w_oor;
                    r_state <= R_BEAT;
                end
                R_BEAT: begin
                    if (s_axi_rready) begin
                        if (r_rlast) begin
                            r_state <= IDLE;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_axi_awready = w_aw_grant;
    assign s_axi_arready = w_ar_grant;
    assign s_axi_wready  = (r_state == W_DATA);
    assign s_axi_bvalid  = (r_state == W_RESP);
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = (r_state == R_BEAT);
    assign s_axi_rid     = r_rid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    // The memory read register holds while no access is issued, so gating by
    // state alone keeps rdata stable under back-pressure and zero otherwise.
    assign s_axi_rdata   = ((r_state == R_BEAT) && !r_rbad) ? w_mem_rdata : '0;

    logic w_unused;
    assign w_unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_mem_slave
// Description : Self-checking bench for axi_mem_slave. Directed scenarios plus
//               randomized transactions, compared against a word-array model
//               of memory contents, response codes and handshake latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_slave;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          BOUND = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    always #5 clk = ~clk;

    axi_mem_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .ID_WIDTH   (4),
        .MEM_DEPTH  (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awlock  (1'b0),
        .s_axi_awcache (4'h3),
        .s_axi_awprot  (3'h0),
        .s_axi_awqos   (4'h0),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arlock  (1'b0),
        .s_axi_arcache (4'h3),
        .s_axi_arprot  (3'h0),
        .s_axi_arqos   (4'h0),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    // ------------------------------------------------------------------ model
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] mdl_mem [DEPTH];
    bit          mdl_prio_rd;          // next simultaneous request goes to read
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int k);
        return (burst == 2'b00) ? a : a + 32'(4 * k);
    endfunction

    function automatic bit is_oor(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a < BASE) || ((off >> 2) >= 32'(DEPTH));
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic bit hdr_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd2) || (burst >= 2'd2);
    endfunction

    task automatic gen_wdata(input int len, input bit full);
        wd_q.delete();
        ws_q.delete();
        for (int k = 0; k <= len; k++) begin
            wd_q.push_back($urandom);
            ws_q.push_back(full ? 4'hF : 4'($urandom_range(0, 15)));
        end
    endtask

    // --------------------------------------------------------------- drivers
    // mode 0: drive and handshake AW; 1: AW already driven; 2: AW already accepted.
    // Tasks start and end just after a rising edge.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
        int          t;
        bit          err;
        logic [31:0] a;
        int          idx;
        if (mode == 0) begin
            s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
            s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        end
        if (mode != 2) begin
            @(negedge clk);
            t = 0;
            while (!s_axi_awready && t < BOUND) begin @(negedge clk); t++; end
            check("aw_handshake", s_axi_awready, 1'b1);
            check("ar_blocked_by_aw", s_axi_arready, 1'b0);
            @(posedge clk); #1;
            s_axi_awvalid = 1'b0;
        end
        mdl_prio_rd = 1'b1;
        err = hdr_bad(size, burst);
        for (int k = 0; k <= int'(len); k++) begin
            if (k > 0 && $urandom_range(0, 3) == 0) begin
                s_axi_wvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            s_axi_wdata = wd_q[k]; s_axi_wstrb = ws_q[k];
            s_axi_wlast = (k == int'(len)); s_axi_wvalid = 1'b1;
            @(negedge clk);
            if (k == 0) check("wready_latency", s_axi_wready, 1'b1);
            t = 0;
            while (!s_axi_wready && t < BOUND) begin @(negedge clk); t++; end
            check("w_handshake", s_axi_wready, 1'b1);
            @(posedge clk); #1;
            a = beat_addr(addr, burst, k);
            if (!err && !is_oor(a)) begin
                idx = word_idx(a);
                for (int b = 0; b < 4; b++)
                    if (ws_q[k][b]) mdl_mem[idx][8*b +: 8] = wd_q[k][8*b +: 8];
            end
            err = err || is_oor(a);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        @(negedge clk);
        check("bvalid_latency", s_axi_bvalid, 1'b1);
        check("bid", s_axi_bid, id);
        check("bresp", s_axi_bresp, err ? 2'b10 : 2'b00);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("bvalid_hold", s_axi_bvalid, 1'b1);
        end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    // abort_beat >= 0: stall that beat 5 cycles, then apply reset instead of accepting it.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           input int abort_beat);
        int          t;
        int          nst;
        bit          err, bad;
        logic [31:0] a, exp_d;
        if (mode == 0) begin
            s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
            s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        end
        if (mode != 2) begin
            @(negedge clk);
            t = 0;
            while (!s_axi_arready && t < BOUND) begin @(negedge clk); t++; end
            check("ar_handshake", s_axi_arready, 1'b1);
            check("aw_blocked_by_ar", s_axi_awready, 1'b0);
            @(posedge clk); #1;
            s_axi_arvalid = 1'b0;
        end
        mdl_prio_rd = 1'b0;
        err = hdr_bad(size, burst);
        for (int k = 0; k <= int'(len); k++) begin
            a     = beat_addr(addr, burst, k);
            bad   = err || is_oor(a);
            err   = bad;
            exp_d = bad ? 32'h0 : mdl_mem[word_idx(a)];
            @(negedge clk);
            check("rvalid_fetch_bubble", s_axi_rvalid, 1'b0);
            t = 0;
            while (!s_axi_rvalid && t < BOUND) begin @(negedge clk); t++; end
            check("rvalid", s_axi_rvalid, 1'b1);
            check("rdata", s_axi_rdata, exp_d);
            check("rresp", s_axi_rresp, bad ? 2'b10 : 2'b00);
            check("rlast", s_axi_rlast, k == int'(len));
            check("rid", s_axi_rid, id);
            nst = (k == abort_beat) ? 5 : int'($urandom_range(0, 2));
            repeat (nst) begin
                @(negedge clk);
                check("rdata_hold", s_axi_rdata, exp_d);
                check("rresp_hold", s_axi_rresp, bad ? 2'b10 : 2'b00);
                check("rlast_hold", s_axi_rlast, k == int'(len));
            end
            if (k == abort_beat) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("rvalid_after_reset", s_axi_rvalid, 1'b0);
                check("bvalid_after_reset", s_axi_bvalid, 1'b0);
                check("rdata_after_reset", s_axi_rdata, 32'h0);
                rst_n = 1'b1;
                mdl_prio_rd = 1'b0;
                @(posedge clk); #1;
                return;
            end
            s_axi_rready = 1'b1;
            @(posedge clk); #1;
            s_axi_rready = 1'b0;
        end
    endtask

    // Both address channels raised together; model decides which wins.
    task automatic do_both(input logic [3:0] wid, input logic [31:0] waddr, input logic [7:0] wlen,
                           input logic [3:0] rid, input logic [31:0] raddr, input logic [7:0] rlen);
        bit wr_first;
        s_axi_awid = wid; s_axi_awaddr = waddr; s_axi_awlen = wlen;
        s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        s_axi_arid = rid; s_axi_araddr = raddr; s_axi_arlen = rlen;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        wr_first = !mdl_prio_rd;
        @(negedge clk);
        check("both_awready", s_axi_awready, wr_first);
        check("both_arready", s_axi_arready, !wr_first);
        @(posedge clk); #1;
        if (wr_first) begin
            s_axi_awvalid = 1'b0;
            do_write(wid, waddr, wlen, 3'd2, 2'b01, 2);
            do_read(rid, raddr, rlen, 3'd2, 2'b01, 1, -1);
        end else begin
            s_axi_arvalid = 1'b0;
            do_read(rid, raddr, rlen, 3'd2, 2'b01, 2, -1);
            do_write(wid, waddr, wlen, 3'd2, 2'b01, 1);
        end
    endtask

    task automatic rand_txn(output logic [3:0] id, output logic [31:0] addr, output logic [7:0] len,
                            output logic [2:0] size, output logic [1:0] burst);
        int sel;
        id   = 4'($urandom_range(0, 15));
        len  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 20)) : 8'($urandom_range(0, 7));
        sel  = $urandom_range(0, 19);
        burst = (sel < 15) ? 2'b01 : (sel < 18) ? 2'b00 : 2'($urandom_range(2, 3));
        size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
        sel  = $urandom_range(0, 9);
        if (sel == 0)      addr = BASE - 32'(4 * $urandom_range(1, 4));
        else if (sel == 1) addr = BASE + 32'(4 * (DEPTH - 2 + $urandom_range(0, 4)));
        else               addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
    endtask

    // --------------------------------------------------------------- sequence
    logic [3:0]  r_id_a;
    logic [31:0] r_addr_a;
    logic [7:0]  r_len_a;
    logic [2:0]  r_size_a;
    logic [1:0]  r_burst_a;

    initial begin
        rst_n = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd2;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd2;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        mdl_prio_rd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", s_axi_awready, 1'b0);
        check("rst_wready",  s_axi_wready,  1'b0);
        check("rst_arready", s_axi_arready, 1'b0);
        check("rst_bvalid",  s_axi_bvalid,  1'b0);
        check("rst_rvalid",  s_axi_rvalid,  1'b0);
        check("rst_bresp",   s_axi_bresp,   2'b00);
        check("rst_rresp",   s_axi_rresp,   2'b00);
        check("rst_rdata",   s_axi_rdata,   32'h0);
        check("rst_rlast",   s_axi_rlast,   1'b0);
        check("rst_bid",     s_axi_bid,     4'h0);
        check("rst_rid",     s_axi_rid,     4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill the whole memory with one maximal INCR burst.
        gen_wdata(255, 1'b1);
        do_write(4'h1, BASE, 8'd255, 3'd2, 2'b01, 0);

        // Single-beat write then read.
        wd_q = '{32'hDEAD_BEEF}; ws_q = '{4'hF};
        do_write(4'h3, BASE + 32'h10, 8'd0, 3'd2, 2'b01, 0);
        do_read(4'h5, BASE + 32'h10, 8'd0, 3'd2, 2'b01, 0, -1);

        // Four-beat INCR.
        wd_q = '{32'd1, 32'd2, 32'd3, 32'd4}; ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'h6, BASE + 32'h40, 8'd3, 3'd2, 2'b01, 0);
        do_read(4'h7, BASE + 32'h40, 8'd3, 3'd2, 2'b01, 0, -1);

        // Byte strobes merge into an all-ones word.
        wd_q = '{32'hFFFF_FFFF}; ws_q = '{4'hF};
        do_write(4'h2, BASE + 32'h80, 8'd0, 3'd2, 2'b01, 0);
        wd_q = '{32'h1234_5678}; ws_q = '{4'b0101};
        do_write(4'h2, BASE + 32'h80, 8'd0, 3'd2, 2'b01, 0);
        do_read(4'h2, BASE + 32'h80, 8'd0, 3'd2, 2'b01, 0, -1);
        check("strobe_merge_model", mdl_mem[32], 32'hFF34_FF78);

        // Out of range, WRAP and FIXED bursts.
        do_read(4'h8, BASE + 32'(4 * DEPTH), 8'd0, 3'd2, 2'b01, 0, -1);
        gen_wdata(0, 1'b1);
        do_write(4'h9, BASE + 32'(4 * DEPTH), 8'd0, 3'd2, 2'b01, 0);
        do_read(4'h8, BASE - 32'h4, 8'd1, 3'd2, 2'b01, 0, -1);
        gen_wdata(3, 1'b1);
        do_write(4'hA, BASE + 32'h20, 8'd3, 3'd2, 2'b10, 0);
        do_read(4'hA, BASE + 32'h20, 8'd3, 3'd2, 2'b10, 0, -1);
        do_read(4'hA, BASE + 32'h20, 8'd3, 3'd2, 2'b01, 0, -1);
        gen_wdata(2, 1'b1);
        do_write(4'hB, BASE + 32'h30, 8'd2, 3'd2, 2'b00, 0);
        do_read(4'hB, BASE + 32'h30, 8'd2, 3'd2, 2'b00, 0, -1);

        // Simultaneous requests, twice in a row.
        gen_wdata(1, 1'b1);
        do_both(4'hC, BASE + 32'h100, 8'd1, 4'hD, BASE + 32'h100, 8'd1);
        gen_wdata(0, 1'b1);
        do_both(4'hE, BASE + 32'h104, 8'd0, 4'hF, BASE + 32'h100, 8'd2);

        // Bursts crossing the top of memory.
        gen_wdata(7, 1'b0);
        do_write(4'h4, BASE + 32'(4 * (DEPTH - 2)), 8'd7, 3'd2, 2'b01, 0);
        do_read(4'h4, BASE + 32'(4 * (DEPTH - 4)), 8'd255, 3'd2, 2'b01, 0, -1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            rand_txn(r_id_a, r_addr_a, r_len_a, r_size_a, r_burst_a);
            gen_wdata(int'(r_len_a), $urandom_range(0, 1) == 1);
            case ($urandom_range(0, 4))
                0:       do_both(r_id_a, BASE + 32'(4 * $urandom_range(0, DEPTH - 8)), 8'($urandom_range(0, 3)),
                                 ~r_id_a, BASE + 32'(4 * $urandom_range(0, DEPTH - 8)), 8'($urandom_range(0, 3)));
                1, 2:    do_write(r_id_a, r_addr_a, r_len_a, r_size_a, r_burst_a, 0);
                default: do_read(r_id_a, r_addr_a, r_len_a, r_size_a, r_burst_a, 0, -1);
            endcase
        end

        // Back-pressure on beat 1, then reset mid-burst; the responder must
        // come back idle with write priority.
        do_read(4'h6, BASE + 32'h40, 8'd2, 3'd2, 2'b01, 0, 1);
        wd_q = '{32'hCAFE_F00D}; ws_q = '{4'hF};
        do_both(4'h1, BASE + 32'h44, 8'd0, 4'h2, BASE + 32'h40, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 full-protocol memory responder: accepts single-beat and INCR/FIXED burst reads and writes from an AXI4 master and serves them from on-chip single-port word memory. Sits on the DDR side of the GPU wrapper's AXI4 master port. It is the simulation and bring-up stand-in for the PS DDR path, and it is synthesizable as a BRAM scratchpad. One transaction is in flight at a time, and reads and writes are serialized.

## Interface
- DATA_WIDTH, 32: data bus width; fixed at 32 for this revision.
- ADDR_WIDTH, 32: byte address width.
- ID_WIDTH, 4: AXI ID width.
- MEM_DEPTH, 1024: number of 32-bit words.
- BASE_ADDR, 32'h0: byte address of word 0.
- Port groups below are listed as direction, then widths in signal order.
- clk in 1: clock.
- rst_n in 1: reset, synchronous, active-low.
- s_axi_awid/awaddr/awlen/awsize/awburst in ID_WIDTH/ADDR_WIDTH/8/3/2: write address.
- s_axi_awlock/awcache/awprot/awqos in 1/4/3/4: accepted and ignored.
- s_axi_awvalid in 1, s_axi_awready out 1: write address handshake.
- s_axi_wdata/wstrb/wlast/wvalid in DATA_WIDTH/DATA_WIDTH/8/1/1, s_axi_wready out 1: write data channel.
- s_axi_bid/bresp/bvalid out ID_WIDTH/2/1, s_axi_bready in 1: write response channel.
- s_axi_arid/araddr/arlen/arsize/arburst in ID_WIDTH/ADDR_WIDTH/8/3/2: read address.
- s_axi_arlock/arcache/arprot/arqos in 1/4/3/4: accepted and ignored.
- s_axi_arvalid in 1, s_axi_arready out 1: read address handshake.
- s_axi_rid/rdata/rresp/rlast/rvalid out ID_WIDTH/DATA_WIDTH/2/1/1, s_axi_rready in 1: read data channel.

## Operation
- FSM states: IDLE, W_DATA, W_RESP, R_FETCH, R_BEAT.
- IDLE, arbitration (combinational):
  - awready = awvalid && (!arvalid || prio==WR).
  - arready = arvalid && (!awvalid || prio==RD).
  - On a grant, latch id, address, len, size and burst; clear beat counter and err flag.
  - prio becomes the opposite of the type just granted. prio resets to WR.
- Error conditions, detected at the address handshake; any one sets err:
  - size != 3'b010.
  - burst == WRAP or burst == 2'b11.
- Per-beat word index = (addr − BASE_ADDR) >> 2, with addr 4-byte aligned (low 2 bits ignored).
  - INCR: addr += 4 per beat.
  - FIXED: addr held.
- A beat is out of range if addr < BASE_ADDR or index ≥ MEM_DEPTH. An out-of-range beat sets err.
- Write path:
  - AW grant → W_DATA. wready=1 in W_DATA only; W beats offered before the AW grant wait.
  - Each W handshake writes wdata byte lanes enabled by wstrb, unless err is set or the beat is out of range.
  - The burst ends on the beat where count == awlen. If wlast != (count==awlen) on any beat, set err.
  - Burst end → W_RESP. bvalid=1, bid = latched awid, bresp = err ? 2'b10 (SLVERR) : 2'b00.
  - bvalid && bready → IDLE.
- Read path:
  - AR grant → R_FETCH, which issues the memory read for the current addr.
  - Next cycle → R_BEAT. rvalid=1, rdata = memory word (32'h0 if err or out of range), rid = latched arid, rresp per beat (SLVERR if err or this beat out of range), rlast = (count==arlen).
  - rvalid && rready: if rlast → IDLE, else advance addr, count++ and → R_FETCH.
- rdata, rresp and rlast stay stable while rvalid && !rready.

## Timing
- Reset values:
  - awready, wready, arready, bvalid and rvalid are 0.
  - bresp, rresp, rdata, rlast, bid and rid are 0.
  - State is IDLE and prio is WR.
  - Memory contents are not reset.
- Reset mid-burst aborts the transaction; no B or R response is issued.
- AW/AR ready appear in the same cycle as valid, when IDLE and granted.
- Write: first wready is 1 cycle after the AW handshake. One beat per cycle. bvalid is 1 cycle after the last W handshake.
- Read: first rvalid is 2 cycles after the AR handshake. Sustained throughput is 1 beat per 2 cycles (R_FETCH bubble).
- A len=255 INCR burst crossing the top of memory returns SLVERR on the overflowing beats only.
- Simultaneous awvalid and arvalid in IDLE: exactly one is granted, per prio; the other stays pending.

## Structure
- Shared package axi_pkg:
  - burst_t {FIXED, INCR, WRAP}.
  - resp_t {OKAY, EXOKAY, SLVERR, DECERR}.
  - Constant AXI_SIZE_4B = 3'b010.
  - State enum slv_state_t.
- Sub-module axi_mem_bram: single-port, byte-enable write, 1-cycle registered read, MEM_DEPTH × 32.

## Test plan
- Write 32'hDEADBEEF to 0x10 (len 0), then read 0x10 → bresp OKAY, rdata DEADBEEF, rlast=1, rid = arid.
- INCR write len=3 at 0x40 with data 1,2,3,4, then INCR read len=3 → rdata 1,2,3,4 and rlast only on the 4th beat.
- Write 0xFFFFFFFF, then write 0x12345678 with wstrb 4'b0101 → read returns 0xFF34FF78.
- Read at BASE_ADDR + 4*MEM_DEPTH → rresp SLVERR, rdata 0. Write there → bresp SLVERR, memory unchanged. WRAP burst → SLVERR.
- awvalid and arvalid asserted together twice in a row → write granted first, then read; no responses lost.
- Read len=2 with rready low 5 cycles on beat 1 → rdata held stable. Then assert rst_n=0 mid-burst → rvalid=0 next cycle, state IDLE.
